// File: rtl/serial_regbank_pkg.sv
// Shared mode encodings, default out-of-range read word and sizing helper
// for the serial register bank.
package serial_regbank_pkg;

    localparam logic [1:0] MODE_RW    = 2'd0;
    localparam logic [1:0] MODE_RO    = 2'd1;
    localparam logic [1:0] MODE_PULSE = 2'd2;
    localparam logic [1:0] MODE_W1C   = 2'd3;

    localparam logic [31:0] BAD_RD_DEFAULT = 32'hBADADD00;

    function automatic int clog2(input int value);
        int width;
        width = 32'sd0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 32'sd1) begin
            width = width + 32'sd1;
        end
        return width;
    endfunction

endpackage

// File: rtl/regbank_entry.sv
// One register of the serial bank: storage, access-mode behaviour and the
// shared per-register pulse timer.
module regbank_entry
    import serial_regbank_pkg::*;
#(
    parameter int              DW        = 32,
    parameter logic [1:0]      MODE_SEL  = MODE_RW,
    parameter logic [DW-1:0]   RESET_VAL = {DW{1'b0}},
    parameter int              PULSE_LEN = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] data_wr,
    input  logic [DW-1:0] status,
    output logic [DW-1:0] value,
    output logic [DW-1:0] rd_value
);

    localparam int            CW       = clog2(PULSE_LEN + 32'sd1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_LEN);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'sd1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [DW-1:0] ZERO     = {DW{1'b0}};
    // W1C and RO contents never start from the configured reset word.
    localparam logic [DW-1:0] RST_CONTENT =
        ((MODE_SEL == MODE_RW) || (MODE_SEL == MODE_PULSE)) ? RESET_VAL : ZERO;

    logic [DW-1:0] value_r;
    logic [CW-1:0] cnt_r;

    // Register update according to the access mode of this entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            value_r <= RST_CONTENT;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (MODE_SEL)
                MODE_RW: begin
                    if (wr_en) value_r <= data_wr;
                end
                MODE_PULSE: begin
                    // A write during an active pulse merges bits and restarts the timer.
                    if (wr_en) begin
                        value_r <= (cnt_r != CNT_ZERO) ? (value_r | data_wr) : data_wr;
                        cnt_r   <= CNT_LOAD;
                    end else if (cnt_r == CNT_ONE) begin
                        value_r <= ZERO;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                MODE_W1C: begin
                    value_r <= (value_r & ~(wr_en ? data_wr : ZERO)) | status;
                end
                default: begin
                    value_r <= ZERO;
                end
            endcase
        end
    end

    assign value    = value_r;
    assign rd_value = (MODE_SEL == MODE_RO) ? status : value_r;

endmodule

// File: rtl/serial_regbank.sv
// Parametrised serial register bank: write-edge qualification, address
// decode, out-of-range detection and registered readback.
module serial_regbank
    import serial_regbank_pkg::*;
#(
    parameter int                   NREG      = 16,
    parameter int                   DW        = 32,
    parameter int                   AW        = 8,
    parameter logic [2*NREG-1:0]    MODE      = {(2*NREG){1'b0}},
    parameter logic [NREG*DW-1:0]   RESET_VAL = {(NREG*DW){1'b0}},
    parameter int                   PULSE_LEN = 1,
    parameter logic [31:0]          BAD_RD    = BAD_RD_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [AW-1:0]        adr_in,
    input  logic [DW-1:0]        data_wr,
    output logic [DW-1:0]        data_rd,
    output logic                 rd_valid,
    output logic [NREG*DW-1:0]   regs_out,
    input  logic [NREG*DW-1:0]   status_in,
    output logic [NREG-1:0]      wr_strobe,
    output logic                 adr_err
);

    localparam logic [DW-1:0] BAD_RD_W = DW'(BAD_RD);
    localparam logic [AW-1:0] NREG_W   = AW'(NREG);

    logic            wr_s;
    logic [AW-2:0]   adr_s;
    logic [AW-1:0]   adr_ext_s;
    logic            in_range_s;
    logic            wr_edge_s;
    logic            wr_q_r;
    logic [AW-2:0]   adr_q_r;
    logic            adr_seen_r;
    logic [NREG-1:0] hit_s;
    logic [DW-1:0]   rd_sel_s;
    logic [DW-1:0]   rd_val_s [NREG];

    assign wr_s       = adr_in[AW-1];
    assign adr_s      = adr_in[AW-2:0];
    assign adr_ext_s  = {1'b0, adr_s};
    assign in_range_s = (adr_ext_s < NREG_W);
    assign wr_edge_s  = wr_s & ~wr_q_r;

    // One-hot write decode and AND-OR read select over all entries.
    always_comb begin
        hit_s    = {NREG{1'b0}};
        rd_sel_s = {DW{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            hit_s[i] = wr_edge_s & (adr_ext_s == AW'(i));
            rd_sel_s = rd_sel_s | ({DW{adr_ext_s == AW'(i)}} & rd_val_s[i]);
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        regbank_entry #(
            .DW        (DW),
            .MODE_SEL  (MODE[2*g +: 2]),
            .RESET_VAL (RESET_VAL[DW*g +: DW]),
            .PULSE_LEN (PULSE_LEN)
        ) u_entry (
            .clock    (clock),
            .reset    (reset),
            .wr_en    (hit_s[g]),
            .data_wr  (data_wr),
            .status   (status_in[DW*g +: DW]),
            .value    (regs_out[DW*g +: DW]),
            .rd_value (rd_val_s[g])
        );
    end

    // Edge history, address stability tracking and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q_r     <= 1'b0;
            adr_q_r    <= {(AW-1){1'b0}};
            adr_seen_r <= 1'b0;
            data_rd    <= {DW{1'b0}};
            rd_valid   <= 1'b0;
            wr_strobe  <= {NREG{1'b0}};
            adr_err    <= 1'b0;
        end else begin
            wr_q_r     <= wr_s;
            adr_q_r    <= adr_s;
            adr_seen_r <= 1'b1;
            data_rd    <= in_range_s ? rd_sel_s : BAD_RD_W;
            rd_valid   <= adr_seen_r & (adr_s == adr_q_r);
            wr_strobe  <= hit_s;
            adr_err    <= wr_edge_s & ~in_range_s;
        end
    end

endmodule

// File: tb/tb_serial_regbank.sv
// Bench for serial_regbank: directed vector table for the multi-cycle corner
// cases, then random traffic, all compared against a behavioural model.
module tb_serial_regbank;

    localparam int NREG = 4;
    localparam int DW   = 32;
    localparam int AW   = 8;
    localparam int CW   = NREG * DW;
    localparam int PLEN = 3;
    localparam logic [2*NREG-1:0] MODE      = {2'd3, 2'd2, 2'd1, 2'd0};
    localparam logic [CW-1:0]     RESET_VAL = {32'h0, 32'h0, 32'h0, 32'h20};
    localparam logic [31:0]       BAD       = 32'hBADADD00;

    logic            clock = 1'b0;
    logic            reset;
    logic [AW-1:0]   adr_in;
    logic [DW-1:0]   data_wr;
    logic [DW-1:0]   data_rd;
    logic            rd_valid;
    logic [CW-1:0]   regs_out;
    logic [CW-1:0]   status_in;
    logic [NREG-1:0] wr_strobe;
    logic            adr_err;
    logic [DW-1:0]   st [NREG];

    assign status_in = {st[3], st[2], st[1], st[0]};

    always #5 clock = ~clock;

    serial_regbank #(
        .NREG(NREG), .DW(DW), .AW(AW), .MODE(MODE), .RESET_VAL(RESET_VAL),
        .PULSE_LEN(PLEN), .BAD_RD(BAD)
    ) dut (
        .clock(clock), .reset(reset), .adr_in(adr_in), .data_wr(data_wr),
        .data_rd(data_rd), .rd_valid(rd_valid), .regs_out(regs_out),
        .status_in(status_in), .wr_strobe(wr_strobe), .adr_err(adr_err)
    );

    // Reference model state: register contents plus remaining pulse lifetime.
    logic [DW-1:0]   m_reg [NREG];
    int              m_left = 0;
    bit              m_wrq  = 1'b0;
    int              m_prev = 0;
    bit              m_seen = 1'b0;
    logic [DW-1:0]   m_rd   = '0;
    bit              m_vld  = 1'b0;
    logic [NREG-1:0] m_stb  = '0;
    bit              m_err  = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic model_step();
        int            a;
        bit            wr;
        bit            fire;
        logic [DW-1:0] clr;
        wr = adr_in[AW-1];
        a  = int'(adr_in[AW-2:0]);
        if (reset) begin
            m_reg[0] = 32'h20; m_reg[1] = '0; m_reg[2] = '0; m_reg[3] = '0;
            m_left = 0; m_wrq = 1'b0; m_prev = 0; m_seen = 1'b0;
            m_rd = '0; m_vld = 1'b0; m_stb = '0; m_err = 1'b0;
        end else begin
            fire = wr && !m_wrq;
            if (a >= NREG)   m_rd = BAD;
            else if (a == 1) m_rd = st[1];
            else             m_rd = m_reg[a];
            m_vld = m_seen && (a == m_prev);
            m_stb = '0;
            m_err = 1'b0;
            if (fire && a >= NREG) m_err = 1'b1;
            else if (fire)         m_stb[a] = 1'b1;
            if (fire && a == 0) m_reg[0] = data_wr;
            if (fire && a == 2) begin
                m_reg[2] = (m_left > 0) ? (m_reg[2] | data_wr) : data_wr;
                m_left   = PLEN;
            end else if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) m_reg[2] = '0;
            end
            clr      = (fire && a == 3) ? data_wr : '0;
            m_reg[3] = (m_reg[3] & ~clr) | st[3];
            m_wrq  = wr;
            m_prev = a;
            m_seen = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check("m_data_rd",   CW'(data_rd),   CW'(m_rd));
        check("m_rd_valid",  CW'(rd_valid),  CW'(m_vld));
        check("m_wr_strobe", CW'(wr_strobe), CW'(m_stb));
        check("m_adr_err",   CW'(adr_err),   CW'(m_err));
        check("m_regs_out",  regs_out,       {m_reg[3], m_reg[2], 32'h0, m_reg[0]});
    endtask

    typedef struct {
        logic          rst;
        logic [AW-1:0] adr;
        logic [DW-1:0] dw;
        logic [DW-1:0] s1;
        logic [DW-1:0] s3;
        logic [4:0]    chk;
        logic [DW-1:0] e_rd;
        logic          e_vld;
        logic [3:0]    e_stb;
        logic          e_err;
        logic [DW-1:0] e_r0;
        logic [DW-1:0] e_r2;
        logic [DW-1:0] e_r3;
    } vec_t;

    // chk bits: 0 read path, 1 strobes, 2 reg0, 3 reg2, 4 reg3
    function automatic vec_t v(input logic rst, input logic [7:0] adr, input logic [31:0] dw,
                               input logic [31:0] s1, input logic [31:0] s3, input logic [4:0] chk,
                               input logic [31:0] rd, input logic vld, input logic [3:0] stb,
                               input logic err, input logic [31:0] r0, input logic [31:0] r2,
                               input logic [31:0] r3);
        vec_t r;
        r.rst = rst; r.adr = adr; r.dw = dw; r.s1 = s1; r.s3 = s3; r.chk = chk;
        r.e_rd = rd; r.e_vld = vld; r.e_stb = stb; r.e_err = err;
        r.e_r0 = r0; r.e_r2 = r2; r.e_r3 = r3;
        return r;
    endfunction

    vec_t tbl [45];

    initial begin : main
        logic [6:0] ra;
        logic       rw;
        for (int i = 0; i < NREG; i++) begin
            m_reg[i] = '0;
            st[i]    = '0;
        end
        reset = 1'b1; adr_in = '0; data_wr = '0;

        tbl[0]  = v(1, 8'h00, 0, 0, 0, 31, 0, 0, 0, 0, 32'h20, 0, 0);
        tbl[1]  = v(1, 8'h00, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = v(0, 8'h00, 0, 0, 0,  1, 32'h20, 0, 0, 0, 0, 0, 0);
        tbl[3]  = v(0, 8'h00, 0, 0, 0,  1, 32'h20, 1, 0, 0, 0, 0, 0);
        tbl[4]  = v(0, 8'h80, 32'hCAFEF00D, 0, 0, 7, 32'h20, 1, 4'h1, 0, 32'hCAFEF00D, 0, 0);
        tbl[5]  = v(0, 8'h80, 32'hCAFEF00D, 0, 0, 3, 32'hCAFEF00D, 1, 0, 0, 0, 0, 0);
        tbl[6]  = v(0, 8'h80, 32'hCAFEF00D, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = v(0, 8'h80, 32'hCAFEF00D, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = v(0, 8'h80, 32'hCAFEF00D, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = v(0, 8'h00, 0, 0, 0, 3, 32'hCAFEF00D, 1, 0, 0, 0, 0, 0);
        tbl[10] = v(0, 8'h82, 1, 0, 0, 11, 0, 0, 4'h4, 0, 0, 1, 0);
        tbl[11] = v(0, 8'h02, 0, 0, 0,  9, 1, 1, 0, 0, 0, 1, 0);
        tbl[12] = v(0, 8'h02, 0, 0, 0,  8, 0, 0, 0, 0, 0, 1, 0);
        tbl[13] = v(0, 8'h02, 0, 0, 0,  8, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = v(0, 8'h82, 1, 0, 0, 10, 0, 0, 4'h4, 0, 0, 1, 0);
        tbl[15] = v(0, 8'h02, 0, 0, 0,  8, 0, 0, 0, 0, 0, 1, 0);
        tbl[16] = v(0, 8'h82, 2, 0, 0, 10, 0, 0, 4'h4, 0, 0, 3, 0);
        tbl[17] = v(0, 8'h02, 0, 0, 0,  8, 0, 0, 0, 0, 0, 3, 0);
        tbl[18] = v(0, 8'h02, 0, 0, 0,  8, 0, 0, 0, 0, 0, 3, 0);
        tbl[19] = v(0, 8'h02, 0, 0, 0,  8, 0, 0, 0, 0, 0, 0, 0);
        tbl[20] = v(0, 8'h03, 0, 0, 5, 16, 0, 0, 0, 0, 0, 0, 5);
        tbl[21] = v(0, 8'h03, 0, 0, 0, 17, 5, 1, 0, 0, 0, 0, 5);
        tbl[22] = v(0, 8'h83, 1, 0, 0, 18, 0, 0, 4'h8, 0, 0, 0, 4);
        tbl[23] = v(0, 8'h03, 0, 0, 0, 16, 0, 0, 0, 0, 0, 0, 4);
        tbl[24] = v(0, 8'h83, 4, 0, 4, 18, 0, 0, 4'h8, 0, 0, 0, 4);
        tbl[25] = v(0, 8'h03, 0, 0, 0, 17, 4, 1, 0, 0, 0, 0, 4);
        tbl[26] = v(0, 8'h01, 0, 32'h12345678, 0, 1, 32'h12345678, 0, 0, 0, 0, 0, 0);
        tbl[27] = v(0, 8'h01, 0, 32'h12345678, 0, 1, 32'h12345678, 1, 0, 0, 0, 0, 0);
        tbl[28] = v(0, 8'h81, 32'hFFFFFFFF, 32'h12345678, 0, 30, 0, 0, 4'h2, 0, 32'hCAFEF00D, 0, 4);
        tbl[29] = v(0, 8'h01, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0);
        tbl[30] = v(0, 8'h89, 32'hFFFFFFFF, 0, 0, 30, 0, 0, 0, 1, 32'hCAFEF00D, 0, 4);
        tbl[31] = v(0, 8'h09, 0, 0, 0, 3, BAD, 1, 0, 0, 0, 0, 0);
        tbl[32] = v(0, 8'h09, 0, 0, 0, 1, BAD, 1, 0, 0, 0, 0, 0);
        tbl[33] = v(0, 8'h82, 1, 0, 0, 10, 0, 0, 4'h4, 0, 0, 1, 0);
        tbl[34] = v(0, 8'h02, 0, 0, 0,  8, 0, 0, 0, 0, 0, 1, 0);
        tbl[35] = v(1, 8'h02, 0, 0, 0, 30, 0, 0, 0, 0, 32'h20, 0, 0);
        tbl[36] = v(0, 8'h02, 0, 0, 0,  8, 0, 0, 0, 0, 0, 0, 0);
        tbl[37] = v(0, 8'h02, 0, 0, 0,  8, 0, 0, 0, 0, 0, 0, 0);
        tbl[38] = v(0, 8'h02, 0, 0, 0,  8, 0, 0, 0, 0, 0, 0, 0);
        tbl[39] = v(1, 8'h80, 32'h11, 0, 0, 6, 0, 0, 0, 0, 32'h20, 0, 0);
        tbl[40] = v(1, 8'h80, 32'h11, 0, 0, 6, 0, 0, 0, 0, 32'h20, 0, 0);
        tbl[41] = v(0, 8'h80, 32'h11, 0, 0, 6, 0, 0, 4'h1, 0, 32'h11, 0, 0);
        tbl[42] = v(0, 8'h80, 32'h22, 0, 0, 6, 0, 0, 0, 0, 32'h11, 0, 0);
        tbl[43] = v(0, 8'h80, 32'h22, 0, 0, 4, 0, 0, 0, 0, 32'h11, 0, 0);
        tbl[44] = v(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 45; i++) begin
            reset = tbl[i].rst; adr_in = tbl[i].adr; data_wr = tbl[i].dw;
            st[1] = tbl[i].s1;  st[3] = tbl[i].s3;
            tick();
            if (tbl[i].chk[0]) begin
                check("tbl_data_rd",  CW'(data_rd),  CW'(tbl[i].e_rd));
                check("tbl_rd_valid", CW'(rd_valid), CW'(tbl[i].e_vld));
            end
            if (tbl[i].chk[1]) begin
                check("tbl_wr_strobe", CW'(wr_strobe), CW'(tbl[i].e_stb));
                check("tbl_adr_err",   CW'(adr_err),   CW'(tbl[i].e_err));
            end
            if (tbl[i].chk[2]) check("tbl_reg0", CW'(regs_out[31:0]),   CW'(tbl[i].e_r0));
            if (tbl[i].chk[3]) check("tbl_reg2", CW'(regs_out[95:64]),  CW'(tbl[i].e_r2));
            if (tbl[i].chk[4]) check("tbl_reg3", CW'(regs_out[127:96]), CW'(tbl[i].e_r3));
        end

        // Random traffic, including stray resets, held addresses and out-of-range hits.
        ra = 7'd0;
        for (int k = 0; k < 600; k++) begin
            reset = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 2) == 0) begin
                ra = 7'($urandom_range(0, 5));
                if ($urandom_range(0, 9) == 0) ra = 7'd127;
            end
            rw      = ($urandom_range(0, 2) == 0);
            adr_in  = {rw, ra};
            data_wr = $urandom();
            st[0]   = $urandom();
            st[1]   = $urandom();
            st[2]   = $urandom();
            st[3]   = ($urandom_range(0, 5) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
